// File: rtl/ofdm_rx_pkg.sv
// Shared types and constants for the OFDM receive frame sequencer.
package ofdm_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CP,
      ST_WINDOW
   } rx_state_t;

   localparam int SYM_IDX_W    = 8;
   localparam int SAMPLE_W_DEF = 12;

   typedef logic [SAMPLE_W_DEF-1:0] sample_t;

endpackage

// File: rtl/ofdm_rx_gap_watchdog.sv
// Counts consecutive idle cycles inside a frame and flags the cycle in which
// the gap limit would be reached.
module ofdm_rx_gap_watchdog #(
   parameter int gap_timeout_g = 32
) (
   input  logic sys_clk_i,
   input  logic sys_init,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int CNT_W = $clog2(gap_timeout_g + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(gap_timeout_g - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge sys_clk_i) begin
      if (sys_init || i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + 1'b1;
      end
   end

   // Expiry is only possible on an idle cycle, so a valid sample always wins.
   assign o_expire = i_enable && (r_count == CNT_LAST);

endmodule

// File: rtl/ofdm_rx_frame_ctrl.sv
// OFDM receive frame sequencer: strips the cyclic prefix of each symbol and
// forwards one FFT window per symbol, aborting the frame on a sample gap.
module ofdm_rx_frame_ctrl
   import ofdm_rx_pkg::*;
#(
   parameter int sample_bit_width_g  = 12,
   parameter int fft_length_g        = 64,
   parameter int cp_length_g         = 16,
   parameter int symbols_per_frame_g = 4,
   parameter int gap_timeout_g       = 32
) (
   input  logic                          sys_clk_i,
   input  logic                          sys_init,
   input  logic [sample_bit_width_g-1:0] rx_data_i,
   input  logic [sample_bit_width_g-1:0] rx_data_q,
   input  logic                          rx_data_valid,
   input  logic                          sync_detect_i,
   output logic [sample_bit_width_g-1:0] fft_data_i_o,
   output logic [sample_bit_width_g-1:0] fft_data_q_o,
   output logic                          fft_data_valid_o,
   output logic                          fft_sym_start_o,
   output logic [SYM_IDX_W-1:0]          sym_idx_o,
   output logic                          frame_active_o,
   output logic                          frame_done_o,
   output logic                          frame_abort_o,
   output logic                          sync_ignored_o
);

   localparam int SMP_MAX = (fft_length_g > cp_length_g) ? fft_length_g : cp_length_g;
   localparam int SMP_W   = $clog2(SMP_MAX + 1);
   localparam int SYM_W   = (symbols_per_frame_g > 1) ? $clog2(symbols_per_frame_g) : 1;

   localparam logic [SMP_W-1:0] CP_LAST  = SMP_W'(cp_length_g - 1);
   localparam logic [SMP_W-1:0] FFT_LAST = SMP_W'(fft_length_g - 1);
   localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(symbols_per_frame_g - 1);

   rx_state_t        r_state;
   logic [SMP_W-1:0] r_smp_cnt;
   logic [SYM_W-1:0] r_sym_cnt;

   rx_state_t        w_state_nxt;
   logic [SMP_W-1:0] w_smp_nxt;
   logic [SYM_W-1:0] w_sym_nxt;
   logic             w_fwd;
   logic             w_start;
   logic             w_done;
   logic             w_abort;
   logic             w_expire;
   logic             w_in_frame;

   assign w_in_frame = (r_state != ST_IDLE);

   ofdm_rx_gap_watchdog #(
      .gap_timeout_g (gap_timeout_g)
   ) u_gap_watchdog (
      .sys_clk_i (sys_clk_i),
      .sys_init  (sys_init),
      .i_clear   (!w_in_frame || rx_data_valid),
      .i_enable  (w_in_frame && !rx_data_valid),
      .o_expire  (w_expire)
   );

   always_ff @(posedge sys_clk_i) begin
      if (sys_init) begin
         r_state   <= ST_IDLE;
         r_smp_cnt <= '0;
         r_sym_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_smp_cnt <= w_smp_nxt;
         r_sym_cnt <= w_sym_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_smp_nxt   = r_smp_cnt;
      w_sym_nxt   = r_sym_cnt;
      w_fwd       = 1'b0;
      w_start     = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // The sync-qualified sample is already CP sample 0.
            if (sync_detect_i && rx_data_valid) begin
               w_sym_nxt = '0;
               if (cp_length_g == 1) begin
                  w_state_nxt = ST_WINDOW;
                  w_smp_nxt   = '0;
               end else begin
                  w_state_nxt = ST_CP;
                  w_smp_nxt   = SMP_W'(1);
               end
            end
         end

         ST_CP: begin
            if (w_expire) begin
               w_state_nxt = ST_IDLE;
               w_smp_nxt   = '0;
               w_sym_nxt   = '0;
               w_abort     = 1'b1;
            end else if (rx_data_valid) begin
               if (r_smp_cnt == CP_LAST) begin
                  w_state_nxt = ST_WINDOW;
                  w_smp_nxt   = '0;
               end else begin
                  w_smp_nxt = r_smp_cnt + 1'b1;
               end
            end
         end

         ST_WINDOW: begin
            if (w_expire) begin
               w_state_nxt = ST_IDLE;
               w_smp_nxt   = '0;
               w_sym_nxt   = '0;
               w_abort     = 1'b1;
            end else if (rx_data_valid) begin
               w_fwd   = 1'b1;
               w_start = (r_smp_cnt == '0);
               if (r_smp_cnt == FFT_LAST) begin
                  w_smp_nxt = '0;
                  if (r_sym_cnt == SYM_LAST) begin
                     w_state_nxt = ST_IDLE;
                     w_sym_nxt   = '0;
                     w_done      = 1'b1;
                  end else begin
                     w_state_nxt = ST_CP;
                     w_sym_nxt   = r_sym_cnt + 1'b1;
                  end
               end else begin
                  w_smp_nxt = r_smp_cnt + 1'b1;
               end
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_smp_nxt   = '0;
            w_sym_nxt   = '0;
         end
      endcase
   end

   // Data and index are held at zero between forwarded samples.
   always_ff @(posedge sys_clk_i) begin
      if (sys_init) begin
         fft_data_i_o     <= '0;
         fft_data_q_o     <= '0;
         fft_data_valid_o <= 1'b0;
         fft_sym_start_o  <= 1'b0;
         sym_idx_o        <= '0;
         frame_active_o   <= 1'b0;
         frame_done_o     <= 1'b0;
         frame_abort_o    <= 1'b0;
         sync_ignored_o   <= 1'b0;
      end else begin
         fft_data_i_o     <= w_fwd ? rx_data_i : '0;
         fft_data_q_o     <= w_fwd ? rx_data_q : '0;
         fft_data_valid_o <= w_fwd;
         fft_sym_start_o  <= w_start;
         sym_idx_o        <= w_fwd ? SYM_IDX_W'(r_sym_cnt) : '0;
         frame_active_o   <= (w_state_nxt != ST_IDLE);
         frame_done_o     <= w_done;
         frame_abort_o    <= w_abort;
         if (sync_detect_i && w_in_frame) begin
            sync_ignored_o <= 1'b1;
         end
      end
   end

endmodule
